// File: rtl/morse_play_scheduler.sv
// rtl/morse_play_scheduler.sv - buffered Morse character player driving the buzzer enable
//
// Purpose: holds up to DEPTH encoded characters (length + dot/dash pattern),
// supports push / backspace / clear while idle, and on play_req plays the
// whole buffer with standard Morse timing on tone_en.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           push one character (wr_len 1..5, wr_pat bit0 played first)
//   bksp, clear     drop last character / empty buffer
//   play_req, abort start / stop playback
//   speed           unit = UNIT_CYCLES*(speed+1), latched at play start
//   tone_en         buzzer enable, high only during marks
//   busy, done      playback active / one-cycle end-of-playback pulse
//   count, cur_idx  stored characters / character being played
//   full            buffer holds DEPTH characters
module morse_play_scheduler #(
    parameter int DEPTH       = 8,
    parameter int UNIT_CYCLES = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [2:0]                 wr_len,
    input  logic [4:0]                 wr_pat,
    input  logic                       bksp,
    input  logic                       clear,
    input  logic                       play_req,
    input  logic                       abort,
    input  logic [1:0]                 speed,
    output logic                       tone_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic                       full
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    // Longest interval is a dash at the slowest speed: 3 units of 4*UNIT_CYCLES.
    localparam int TW = $clog2(12 * UNIT_CYCLES + 1);

    localparam logic [TW-1:0] UNIT_W = TW'(UNIT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MARK  = 3'd2;
    localparam logic [2:0] S_SPACE = 3'd3;
    localparam logic [2:0] S_CGAP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] unit_q, unit_d;
    logic [IW-1:0] cur_idx_q, cur_idx_d;
    logic [2:0]    sym_q, sym_d;
    logic [2:0]    len_q, len_d;
    logic [4:0]    pat_q, pat_d;
    logic [CW-1:0] count_q, count_d;
    logic          tone_q, busy_q, done_q;

    logic [2:0]    len_mem [DEPTH];
    logic [4:0]    pat_mem [DEPTH];

    logic          expired;
    logic          last_sym;
    logic          last_char;
    logic          full_w;
    logic          edit_ok;
    logic          wr_ok;
    logic          mem_we;
    logic [TW-1:0] unit_sel;
    logic [TW-1:0] unit3;
    logic [TW-1:0] load_val;
    logic [7:0]    pat_ext;
    logic          mark_dash;

    assign expired   = (timer_q == TW'(1));
    assign last_sym  = ((sym_q + 3'd1) >= len_q);
    assign last_char = ((CW'(cur_idx_q) + CW'(1)) >= count_q);
    assign full_w    = (count_q == CW'(DEPTH));

    // Buffer edits are only honoured while the player is idle.
    assign edit_ok = (state_q == S_IDLE);
    assign wr_ok   = wr_en && !full_w && (wr_len >= 3'd1) && (wr_len <= 3'd5);
    assign mem_we  = edit_ok && !clear && !bksp && wr_ok;

    always_comb begin
        count_d = count_q;
        if (edit_ok) begin
            if (clear) begin
                count_d = '0;
            end else if (bksp) begin
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
            end else if (wr_ok) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_comb begin
        case (speed)
            2'd0:    unit_sel = UNIT_W;
            2'd1:    unit_sel = UNIT_W + UNIT_W;
            2'd2:    unit_sel = UNIT_W + UNIT_W + UNIT_W;
            default: unit_sel = UNIT_W + UNIT_W + UNIT_W + UNIT_W;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        sym_d     = sym_q;
        len_d     = len_q;
        pat_d     = pat_q;
        unit_d    = unit_q;
        case (state_q)
            S_IDLE: begin
                if (play_req) begin
                    unit_d    = unit_sel;
                    cur_idx_d = '0;
                    state_d   = (count_q != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                len_d   = len_mem[cur_idx_q];
                pat_d   = pat_mem[cur_idx_q];
                sym_d   = 3'd0;
                state_d = S_MARK;
            end
            S_MARK: begin
                if (expired) begin
                    if (!last_sym) begin
                        state_d = S_SPACE;
                    end else if (!last_char) begin
                        state_d = S_CGAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SPACE: begin
                if (expired) begin
                    sym_d   = sym_q + 3'd1;
                    state_d = S_MARK;
                end
            end
            S_CGAP: begin
                if (expired) begin
                    cur_idx_d = cur_idx_q + IW'(1);
                    state_d   = S_LOAD;
                end
            end
            S_DONE: begin
                cur_idx_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
        end
    end

    // Duration of the state being entered; the pattern/symbol used are the
    // next-state values so LOAD->MARK sees the freshly fetched character.
    assign pat_ext   = {3'b000, pat_d};
    assign mark_dash = pat_ext[sym_d];
    assign unit3     = unit_q + (unit_q << 1);

    always_comb begin
        case (state_d)
            S_MARK:  load_val = mark_dash ? unit3 : unit_q;
            S_SPACE: load_val = unit_q;
            S_CGAP:  load_val = unit3;
            default: load_val = TW'(1);
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = load_val;
        end else if (timer_q > TW'(1)) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= TW'(1);
            unit_q    <= UNIT_W;
            cur_idx_q <= '0;
            sym_q     <= 3'd0;
            len_q     <= 3'd0;
            pat_q     <= 5'd0;
            count_q   <= '0;
            tone_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            unit_q    <= unit_d;
            cur_idx_q <= cur_idx_d;
            sym_q     <= sym_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
            count_q   <= count_d;
            // Outputs registered from the next state so they change exactly
            // with the state register and never glitch at boundaries.
            tone_q    <= (state_d == S_MARK);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            len_mem[count_q[IW-1:0]] <= wr_len;
            pat_mem[count_q[IW-1:0]] <= wr_pat;
        end
    end

    assign tone_en = tone_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;
    assign cur_idx = cur_idx_q;
    assign full    = full_w;

endmodule

// File: tb/tb_morse_play_scheduler.sv
// tb/tb_morse_play_scheduler.sv - directed self-checking bench for morse_play_scheduler
module tb_morse_play_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_len = 3'd0;
    logic [4:0] wr_pat = 5'd0;
    logic       bksp = 1'b0;
    logic       clear = 1'b0;
    logic       play_req = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       tone_en, busy, done, full;
    logic [3:0] count;
    logic [2:0] cur_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tones [$];
    logic [2:0] idxs [$];
    int         runs [$];
    int         exp_q [$];
    logic       got_done;

    morse_play_scheduler #(.DEPTH(8), .UNIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_len(wr_len), .wr_pat(wr_pat),
        .bksp(bksp), .clear(clear), .play_req(play_req), .abort(abort),
        .speed(speed), .tone_en(tone_en), .busy(busy), .done(done),
        .count(count), .cur_idx(cur_idx), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] len, input logic [4:0] pat);
        wr_en = 1'b1; wr_len = len; wr_pat = pat;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Plays the buffer and records tone_en per cycle from the cycle after
    // play_req up to and including the done cycle.
    task automatic run_play(input logic [1:0] spd);
        logic prev;
        speed = spd; play_req = 1'b1;
        tick();
        play_req = 1'b0;
        tones.delete(); idxs.delete(); runs.delete();
        got_done = 1'b0;
        prev = 1'b0;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            tones.push_back(tone_en);
            if (tone_en && !prev) idxs.push_back(cur_idx);
            prev = tone_en;
            if (done) got_done = 1'b1;
            else tick();
        end
        check("done_seen", got_done, 1);
        for (int i = 0; i < tones.size(); i++) begin
            if (i == 0 || tones[i] != tones[i-1]) runs.push_back(1);
            else runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
    endtask

    task automatic check_runs(input string tag);
        check({tag, "_nruns"}, runs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < runs.size()) check($sformatf("%s_run%0d", tag, i), runs[i], exp_q[i]);
        end
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_tone", tone_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_idx", cur_idx, 0);
        check("rst_full", full, 0);

        // E at speed 0: LOAD, 4-cycle dot, DONE; play_req..done spans 7 cycles
        push(3'd1, 5'b00000);
        check("e_count", count, 1);
        speed = 2'd0; play_req = 1'b1;
        tick();
        play_req = 1'b0;
        check("e_busy_t1", busy, 1);
        check("e_tone_t1", tone_en, 0);
        tick();
        check("e_tone_t2", tone_en, 1);
        tick(); tick(); tick();
        check("e_tone_t5", tone_en, 1);
        tick();
        check("e_tone_t6", tone_en, 0);
        check("e_done_t6", done, 1);
        check("e_busy_t6", busy, 1);
        tick();
        check("e_busy_t7", busy, 0);
        check("e_done_t7", done, 0);

        // A at speed 1 (unit 8): dot 8, space 8, dash 24
        do_clear();
        push(3'd2, 5'b00010);
        run_play(2'd1);
        exp_q = '{1, 8, 8, 24, 1};
        check_runs("a");
        check("a_total", tones.size() + 1, 43);
        tick();
        check("a_busy_after", busy, 0);

        // E T E: inter-character low run is 12 gap cycles plus the LOAD cycle
        do_clear();
        push(3'd1, 5'b00000);
        push(3'd1, 5'b00001);
        push(3'd1, 5'b00000);
        run_play(2'd0);
        exp_q = '{1, 4, 13, 12, 13, 4, 1};
        check_runs("ete");
        check("ete_nidx", idxs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < idxs.size()) check($sformatf("ete_idx%0d", i), idxs[i], i);
        end
        tick();
        check("ete_count_after", count, 3);
        check("ete_idx_after", cur_idx, 0);

        // Fill, overflow, backspace, priority, bad lengths
        do_clear();
        for (int i = 0; i < 9; i++) push(3'd1, 5'b00000);
        check("fill_count", count, 8);
        check("fill_full", full, 1);
        bksp = 1'b1;
        tick();
        bksp = 1'b0;
        check("bksp_count", count, 7);
        check("bksp_full", full, 0);
        bksp = 1'b1; wr_en = 1'b1; wr_len = 3'd1;
        tick();
        bksp = 1'b0; wr_en = 1'b0;
        check("bksp_wr_count", count, 6);
        push(3'd0, 5'b00000);
        check("len0_count", count, 6);
        push(3'd6, 5'b00000);
        check("len6_count", count, 6);
        clear = 1'b1; wr_en = 1'b1; wr_len = 3'd1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        check("clear_wr_count", count, 0);

        // Empty buffer: bksp ignored, play gives only a done pulse
        bksp = 1'b1;
        tick();
        bksp = 1'b0;
        check("bksp_empty", count, 0);
        run_play(2'd0);
        check("empty_cycles", tones.size(), 1);
        check("empty_nruns", runs.size(), 1);
        check("empty_tone", tones[0], 0);
        tick();
        check("empty_busy_after", busy, 0);
        check("empty_done_after", done, 0);

        // Abort during a dash, with a write attempted while busy
        push(3'd1, 5'b00001);
        speed = 2'd0; play_req = 1'b1;
        tick();
        play_req = 1'b0;
        wr_en = 1'b1; wr_len = 3'd1;
        tick();
        wr_en = 1'b0;
        check("busy_wr_count", count, 1);
        tick(); tick();
        check("abort_pre_tone", tone_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_tone", tone_en, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 1);
        tick();
        check("abort_busy_after", busy, 0);
        check("abort_done_after", done, 0);

        // Asynchronous reset in the middle of a mark
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        tick(); tick();
        check("rst_mid_pre_tone", tone_en, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tone", tone_en, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_after_tone", tone_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
